// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the multiplexed 6502 memory bus sequencer:
//   state_e        - sequencer phase encoding (3-bit)
//   OE_DRIVE       - pin enable value while the sequencer drives uio
//   OE_FLOAT       - pin enable value while uio is released / sampled
//   RDATA_TIMEOUT  - read data returned when a wait timeout aborts a read
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADH   = 3'd1,
        ADL   = 3'd2,
        TURN  = 3'd3,
        RDATA = 3'd4,
        WDATA = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [7:0] OE_DRIVE      = 8'hFF;
    localparam logic [7:0] OE_FLOAT      = 8'h00;
    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

endpackage

// File: rtl/mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mem_bus_sequencer
// Time-multiplexes every core memory access over the 8 shared uio pins as
// ADH phase, ADL phase, then a data phase that may be stretched by ext_wait.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req, rw, addr, wdata  core request (held until ack); sampled in IDLE
//   ack, rdata, timeout   completion pulse, read data, wait-timeout pulse
//   bus_in/bus_out/bus_oe uio pin input, output and enable paths
//   ale_h, ale_l          address-high / address-low latch strobes
//   rd_n, we_n            active-low read / write strobes
//   ext_wait              external wait request, honoured in the data phase
//   busy                  high whenever the sequencer is not idle
//
// Every pin-facing output is registered: the output decode runs on the
// next state so each strobe changes only on a clock edge, glitch-free.
// -----------------------------------------------------------------------------
module mem_bus_sequencer
    import bus_pkg::*;
#(
    parameter int TURNAROUND = 1,   // 1..3 released cycles before read sampling
    parameter int MAX_WAIT   = 15   // wait cycles tolerated before abort
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        timeout,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        ale_h,
    output logic        ale_l,
    output logic        rd_n,
    output logic        we_n,
    input  logic        ext_wait,
    output logic        busy
);

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;          // shared turnaround / wait counter
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        abort_s;               // wait timeout forces DONE this cycle

    logic        ack_q, ack_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic [7:0]  bus_oe_q, bus_oe_d;
    logic        ale_h_q, ale_h_d;
    logic        ale_l_q, ale_l_d;
    logic        rd_n_q, rd_n_d;
    logic        we_n_q, we_n_d;
    logic        busy_q, busy_d;

    // Next-state logic: phase sequencing, request latching, counters, read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        abort_s = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    state_d = ADH;
                    addr_d  = addr;
                    wdata_d = wdata;
                    rw_d    = rw;
                end else begin
                    state_d = IDLE;
                end
            end
            ADH: begin
                state_d = ADL;
            end
            ADL: begin
                cnt_d = 4'd0;
                if (rw_q) begin
                    state_d = TURN;
                end else begin
                    state_d = WDATA;
                end
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = RDATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RDATA: begin
                if (!ext_wait) begin
                    rdata_d = bus_in;
                    state_d = DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    // MAX_WAIT wait cycles already spent: abort in the cycle
                    // that would otherwise have been the last data cycle.
                    rdata_d = RDATA_TIMEOUT;
                    state_d = DONE;
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WDATA: begin
                if (!ext_wait) begin
                    state_d = DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = DONE;
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // req may still be high while the core withdraws it; ignore it.
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so pins are registered with the state.
    always_comb begin
        ack_d     = 1'b0;
        timeout_d = 1'b0;
        bus_out_d = 8'h00;
        bus_oe_d  = OE_FLOAT;
        ale_h_d   = 1'b0;
        ale_l_d   = 1'b0;
        rd_n_d    = 1'b1;
        we_n_d    = 1'b1;
        busy_d    = (state_d != IDLE) ? 1'b1 : 1'b0;
        case (state_d)
            ADH: begin
                bus_out_d = addr_d[15:8];
                bus_oe_d  = OE_DRIVE;
                ale_h_d   = 1'b1;
            end
            ADL: begin
                bus_out_d = addr_d[7:0];
                bus_oe_d  = OE_DRIVE;
                ale_l_d   = 1'b1;
            end
            TURN, RDATA: begin
                // Pins released together with rd_n falling; they are only
                // re-driven after DONE/IDLE, well after rd_n has risen.
                rd_n_d = 1'b0;
            end
            WDATA: begin
                bus_out_d = wdata_d;
                bus_oe_d  = OE_DRIVE;
                we_n_d    = 1'b0;
            end
            DONE: begin
                ack_d     = 1'b1;
                timeout_d = abort_s;
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    // State, latched request and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rw_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    // Registered pin and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            bus_out_q <= 8'h00;
            bus_oe_q  <= OE_FLOAT;
            ale_h_q   <= 1'b0;
            ale_l_q   <= 1'b0;
            rd_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            ale_h_q   <= ale_h_d;
            ale_l_q   <= ale_l_d;
            rd_n_q    <= rd_n_d;
            we_n_q    <= we_n_d;
            busy_q    <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign timeout = timeout_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign ale_h   = ale_h_q;
    assign ale_l   = ale_l_q;
    assign rd_n    = rd_n_q;
    assign we_n    = we_n_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_sequencer
// Self-checking bench. The reference model builds each access as a timeline of
// bus phases (ADH, ADL, TURNAROUND turn cycles, data cycles stretched by the
// chosen wait count and capped at the timeout, DONE) and checks the pins of
// every cycle against that timeline. Outputs are sampled on the falling edge;
// inputs are changed right after sampling.
// -----------------------------------------------------------------------------
module tb_mem_bus_sequencer;

    localparam int TURN_CYC = 1;
    localparam int MAXW     = 15;

    // phase tags used only by the bench timeline
    localparam int P_IDLE = 0;
    localparam int P_ADH  = 1;
    localparam int P_ADL  = 2;
    localparam int P_TURN = 3;
    localparam int P_DATA = 4;
    localparam int P_DONE = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        timeout;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic        ale_h;
    logic        ale_l;
    logic        rd_n;
    logic        we_n;
    logic        ext_wait;
    logic        busy;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    logic [7:0]  rdata_m;       // model of the rdata output
    logic [7:0]  rd_last;       // bus_in driven in the final read data cycle

    mem_bus_sequencer #(
        .TURNAROUND (TURN_CYC),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .timeout  (timeout),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .ale_h    (ale_h),
        .ale_l    (ale_l),
        .rd_n     (rd_n),
        .we_n     (we_n),
        .ext_wait (ext_wait),
        .busy     (busy)
    );

    // 100 MHz style free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // all outputs at their reset values
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {25'd0, busy, ack, timeout, ale_h, ale_l, rd_n, we_n},
            {25'd0, 7'b0000011});
        chk({tag, "_oe"},    {24'd0, bus_oe},  32'h00);
        chk({tag, "_out"},   {24'd0, bus_out}, 32'h00);
        chk({tag, "_rdata"}, {24'd0, rdata},   32'h00);
    endtask

    // pins expected for one phase of the current access
    task automatic chk_phase(input int ph, input bit to, input logic [15:0] a,
                             input logic [7:0] wd, input bit is_rd);
        logic [6:0] exp_ctl;  // busy ack timeout ale_h ale_l rd_n we_n
        logic [7:0] exp_oe;
        logic [7:0] exp_out;
        bit         drive;
        exp_ctl = 7'b1000011;
        exp_oe  = 8'h00;
        exp_out = 8'h00;
        drive   = 1'b0;
        case (ph)
            P_ADH:  begin exp_ctl[3] = 1'b1; exp_oe = 8'hFF; exp_out = a[15:8]; drive = 1'b1; end
            P_ADL:  begin exp_ctl[2] = 1'b1; exp_oe = 8'hFF; exp_out = a[7:0];  drive = 1'b1; end
            P_TURN: begin exp_ctl[1] = 1'b0; end
            P_DATA: begin
                if (is_rd) begin
                    exp_ctl[1] = 1'b0;
                end else begin
                    exp_ctl[0] = 1'b0; exp_oe = 8'hFF; exp_out = wd; drive = 1'b1;
                end
            end
            P_DONE: begin exp_ctl[5] = 1'b1; exp_ctl[4] = to; end
            default: exp_ctl = 7'b0000011;
        endcase
        chk("ctl", {25'd0, busy, ack, timeout, ale_h, ale_l, rd_n, we_n}, {25'd0, exp_ctl});
        chk("oe", {24'd0, bus_oe}, {24'd0, exp_oe});
        if (drive) chk("bus_out", {24'd0, bus_out}, {24'd0, exp_out});
        if (ph == P_DONE) chk("rdata", {24'd0, rdata}, {24'd0, rdata_m});
    endtask

    // one falling-edge sample of an idle cycle
    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_ctl", {25'd0, busy, ack, timeout, ale_h, ale_l, rd_n, we_n},
            {25'd0, 7'b0000011});
        chk("idle_oe", {24'd0, bus_oe}, 32'h00);
        chk("idle_rdata", {24'd0, rdata}, {24'd0, rdata_m});
    endtask

    // Issue one access from an idle falling edge. w = wait cycles requested
    // (above MAXW means ext_wait never drops, i.e. timeout). rd_val < 0 means
    // random final read data.
    task automatic run_access(input bit rw_t, input logic [15:0] a, input logic [7:0] wd,
                              input int w, input int rd_val, input bit keep_req);
        bit         to;
        int         dlen, dstart, total, ph, idx;
        logic [7:0] bi;
        to     = (w > MAXW);
        dlen   = to ? MAXW + 1 : w + 1;
        dstart = rw_t ? 3 + TURN_CYC : 3;
        total  = dstart + dlen;
        req      = 1'b1;
        rw       = rw_t;
        addr     = a;
        wdata    = wd;
        ext_wait = 1'($urandom);
        bus_in   = 8'($urandom);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1)           ph = P_ADH;
            else if (k == 2)      ph = P_ADL;
            else if (k < dstart)  ph = P_TURN;
            else if (k < total)   ph = P_DATA;
            else                  ph = P_DONE;
            if (ph == P_DONE && rw_t) rdata_m = to ? 8'hFF : rd_last;
            chk_phase(ph, to, a, wd, rw_t);
            if (ph == P_DATA) begin
                idx      = k - dstart;
                ext_wait = (idx < w);
                if (idx == dlen - 1 && rd_val >= 0) bi = rd_val[7:0];
                else                                bi = 8'($urandom);
                bus_in = bi;
                if (idx == dlen - 1) rd_last = bi;
            end else begin
                ext_wait = 1'($urandom);
                bus_in   = 8'($urandom);
            end
            // request fields only matter in IDLE; scramble them meanwhile
            addr  = 16'($urandom);
            wdata = 8'($urandom);
            rw    = 1'($urandom);
            if (ph == P_DONE && !keep_req) req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = 16'h0000; wdata = 8'h00;
        bus_in = 8'h00; ext_wait = 1'b0;
        rdata_m = 8'h00; rd_last = 8'h00;
        #1;
        chk_reset_vals("rst_async");
        repeat (2) @(negedge clk);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        idle_cycle();

        // directed cases
        run_access(1'b1, 16'h12A5, 8'h00, 0, 8'h3C, 1'b0);  idle_cycle();
        chk("rd_3c", {24'd0, rdata}, 32'h3C);
        run_access(1'b0, 16'h0200, 8'h7E, 0, -1, 1'b0);     idle_cycle();
        run_access(1'b1, 16'hBEEF, 8'h00, 3, -1, 1'b0);     idle_cycle();
        run_access(1'b0, 16'h0400, 8'hA1, 20, -1, 1'b0);    idle_cycle();
        run_access(1'b1, 16'h0401, 8'h00, 20, -1, 1'b0);    idle_cycle();
        chk("rd_timeout", {24'd0, rdata}, 32'hFF);
        run_access(1'b1, 16'h8000, 8'h00, 15, -1, 1'b0);    idle_cycle();
        run_access(1'b0, 16'h8001, 8'h11, 16, -1, 1'b0);    idle_cycle();

        // back-to-back reads with req held: exactly one idle cycle between
        run_access(1'b1, 16'h1000, 8'h00, 0, -1, 1'b1);     idle_cycle();
        run_access(1'b1, 16'h1001, 8'h00, 1, -1, 1'b0);     idle_cycle();

        // reset in the middle of a stretched write
        req = 1'b1; rw = 1'b0; addr = 16'h4321; wdata = 8'h55; ext_wait = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_we_n", {31'd0, we_n}, 32'd0);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_mid");
        req = 1'b0; ext_wait = 1'b0; rdata_m = 8'h00;
        @(negedge clk);
        chk_reset_vals("rst_mid_hold");
        rst = 1'b0;
        idle_cycle();
        run_access(1'b0, 16'h0200, 8'h7E, 0, -1, 1'b0);     idle_cycle();

        // randomized accesses
        for (int n = 0; n < 40; n++) begin
            bit kr;
            int w;
            int gap;
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 18))
                                             : int'($urandom_range(0, 4));
            kr = 1'($urandom);
            run_access(1'($urandom), 16'($urandom), 8'($urandom), w, -1, kr);
            idle_cycle();
            gap = kr ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
